// File: rtl/sprite_types_pkg.sv
// Shared sprite-pipeline types: matcher active-list entries, fetch scheduler states.
// Pure type/constant package, no logic.
package sprite_types;
  localparam int SPR_AW     = 18;
  localparam int TILE_CNT_W = 5;
  localparam int LB_XW      = 11;
  localparam int TILE_PX    = 16;

  typedef struct packed {
    logic [SPR_AW-1:0]     tilemap_addr;
    logic [TILE_CNT_W-1:0] tile_count;
    logic                  x_flip;
  } active_tilemap_addr_t;

  typedef struct packed {
    logic [LB_XW-1:0]  lb_addr;
    logic [SPR_AW-1:0] tile_bitmap_addr;
  } active_bitmap_addr_t;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, CHECK, MAP_REQ, MAP_WAIT, BMP_REQ, BMP_WAIT, WRITE, DONE, DRAIN
  } sched_state_t;

  function automatic logic sched_busy(input sched_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction
endpackage

// File: rtl/sprite_mem_port.sv
// Single-outstanding req/gnt read port: holds req/addr until granted, tracks the in-flight read.
// Request visible the cycle after issue_i; abort drops an ungranted req and discards an in-flight rvalid.
module sprite_mem_port #(
  parameter int AW = 18
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_i,
  input  logic [AW-1:0] addr_i,
  input  logic          abort_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  output logic          gnt_o,
  output logic          rvld_o,
  output logic          drain_need_o,
  output logic          drained_o
);
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          pend_q, pend_d;
  logic          drop_q, drop_d;

  assign mem_req_o  = req_q;
  assign mem_addr_o = addr_q;

  always_comb begin
    gnt_o        = req_q & mem_gnt_i;
    rvld_o       = mem_rvalid_i & pend_q & ~drop_q;
    drained_o    = mem_rvalid_i & drop_q;
    // A read still owed by the memory after this cycle must be swallowed before restarting.
    drain_need_o = (pend_q & ~mem_rvalid_i) | gnt_o;
    req_d  = req_q;
    addr_d = addr_q;
    pend_d = pend_q;
    drop_d = drop_q;
    if (mem_rvalid_i && pend_q) begin
      pend_d = 1'b0;
      drop_d = 1'b0;
    end
    if (gnt_o) begin
      req_d  = 1'b0;
      pend_d = 1'b1;
    end
    if (issue_i) begin
      req_d  = 1'b1;
      addr_d = addr_i;
    end
    if (abort_i) begin
      req_d  = 1'b0;
      drop_d = drain_need_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      pend_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: rtl/sprite_fetch_sched.sv
// Per-line sprite fetch scheduler: walks the matcher list, reads tilemap then bitmap per tile, writes line buffer.
// One read in flight at a time; stalls on mem_gnt/mem_rvalid; a line pulse while busy restarts (draining if needed).
module sprite_fetch_sched
  import sprite_types::*;
#(
  parameter int MAX_SPRITES = 64,
  parameter int MEM_AW      = 18,
  parameter int MEM_DW      = 32
) (
  input  logic                 clk_draw_i,
  input  logic                 rst_draw_i,
  input  logic                 line_i,
  input  logic                 enable_i,
  output logic [8:0]           sprite_index_o,
  input  logic                 valid_i,
  input  active_tilemap_addr_t tilemap_addr_i,
  input  active_bitmap_addr_t  bitmap_addr_i,
  output logic                 mem_req_o,
  output logic [MEM_AW-1:0]    mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [MEM_DW-1:0]    mem_rdata_i,
  output logic                 lb_we_o,
  output logic [10:0]          lb_x_o,
  output logic                 lb_flip_o,
  output logic [MEM_DW-1:0]    lb_data_o,
  output logic                 busy_o,
  output logic                 overrun_o
);
  localparam logic [8:0] MAX_IDX = 9'(MAX_SPRITES);

  sched_state_t          state_q;
  logic [8:0]            idx_q;
  logic [TILE_CNT_W-1:0] t_q;
  active_tilemap_addr_t  map_q;
  active_bitmap_addr_t   bmp_q;
  logic                  en_q;
  logic                  lb_we_q, lb_flip_q, overrun_q;
  logic [LB_XW-1:0]      lb_x_q;
  logic [MEM_DW-1:0]     lb_data_q;

  logic                  port_issue, port_abort;
  logic [MEM_AW-1:0]     port_addr;
  logic                  port_gnt, port_rvld, port_drain_need, port_drained;
  logic                  idx_ok;
  logic [TILE_CNT_W-1:0] t_nxt, tile_off;
  logic [LB_XW-1:0]      px_off;

  assign idx_ok   = idx_q < MAX_IDX;
  assign t_nxt    = t_q + TILE_CNT_W'(1);
  assign tile_off = map_q.x_flip ? (map_q.tile_count - t_q) : t_q;
  assign px_off   = LB_XW'(tile_off) * LB_XW'(TILE_PX);

  assign port_abort = line_i & sched_busy(state_q);

  always_comb begin
    port_issue = 1'b0;
    port_addr  = '0;
    case (state_q)
      CHECK: if (valid_i && idx_ok) begin
        port_issue = 1'b1;
        port_addr  = MEM_AW'(tilemap_addr_i.tilemap_addr);
      end
      MAP_WAIT: if (port_rvld) begin
        port_issue = 1'b1;
        port_addr  = MEM_AW'(bmp_q.tile_bitmap_addr) + MEM_AW'(mem_rdata_i[8:0]);
      end
      WRITE: if (t_q < map_q.tile_count) begin
        port_issue = 1'b1;
        port_addr  = MEM_AW'(map_q.tilemap_addr) + MEM_AW'(t_nxt);
      end
      default: ;
    endcase
  end

  sprite_mem_port #(.AW(MEM_AW)) u_mem_port (
    .clk_i        (clk_draw_i),
    .rst_i        (rst_draw_i),
    .issue_i      (port_issue),
    .addr_i       (port_addr),
    .abort_i      (port_abort),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .gnt_o        (port_gnt),
    .rvld_o       (port_rvld),
    .drain_need_o (port_drain_need),
    .drained_o    (port_drained)
  );

  always_ff @(posedge clk_draw_i) begin
    if (rst_draw_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      t_q       <= '0;
      map_q     <= '0;
      bmp_q     <= '0;
      en_q      <= 1'b0;
      lb_we_q   <= 1'b0;
      lb_x_q    <= '0;
      lb_flip_q <= 1'b0;
      lb_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      lb_we_q   <= 1'b0;
      overrun_q <= port_abort;
      if (line_i) begin
        if (port_abort && port_drain_need) begin
          state_q <= DRAIN;
          en_q    <= enable_i;
        end else if (enable_i) begin
          idx_q   <= '0;
          state_q <= LOOKUP;
        end else begin
          state_q <= DONE;
        end
      end else begin
        case (state_q)
          LOOKUP: state_q <= CHECK;
          CHECK: begin
            if (!valid_i || !idx_ok) begin
              state_q <= DONE;
            end else begin
              map_q   <= tilemap_addr_i;
              bmp_q   <= bitmap_addr_i;
              t_q     <= '0;
              state_q <= MAP_REQ;
            end
          end
          MAP_REQ:  if (port_gnt)  state_q <= MAP_WAIT;
          MAP_WAIT: if (port_rvld) state_q <= BMP_REQ;
          BMP_REQ:  if (port_gnt)  state_q <= BMP_WAIT;
          BMP_WAIT: begin
            if (port_rvld) begin
              state_q   <= WRITE;
              lb_we_q   <= 1'b1;
              lb_data_q <= mem_rdata_i;
              lb_flip_q <= map_q.x_flip;
              lb_x_q    <= bmp_q.lb_addr + px_off;
            end
          end
          WRITE: begin
            if (t_q < map_q.tile_count) begin
              t_q     <= t_nxt;
              state_q <= MAP_REQ;
            end else begin
              idx_q   <= idx_q + 9'd1;
              state_q <= LOOKUP;
            end
          end
          DRAIN: begin
            if (port_drained) begin
              if (en_q) begin
                idx_q   <= '0;
                state_q <= LOOKUP;
              end else begin
                state_q <= DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sprite_index_o = idx_q;
  assign lb_we_o        = lb_we_q;
  assign lb_x_o         = lb_x_q;
  assign lb_flip_o      = lb_flip_q;
  assign lb_data_o      = lb_data_q;
  assign busy_o         = sched_busy(state_q);
  assign overrun_o      = overrun_q;
endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Directed bench for sprite_fetch_sched with a registered matcher model and a req/gnt memory model.
// Memory word at address a is 0xC0000000 | a, so tile index = low 9 bits of the tilemap address.
module tb_sprite_fetch_sched;
  import sprite_types::*;

  logic                 clk = 1'b0;
  logic                 rst, line, enable;
  logic [8:0]           sprite_index;
  logic                 valid;
  active_tilemap_addr_t tilemap_addr;
  active_bitmap_addr_t  bitmap_addr;
  logic                 mem_req, mem_gnt, mem_rvalid;
  logic [17:0]          mem_addr;
  logic [31:0]          mem_rdata;
  logic                 lb_we, lb_flip, busy, overrun;
  logic [10:0]          lb_x;
  logic [31:0]          lb_data;

  always #5 clk = ~clk;

  sprite_fetch_sched #(.MAX_SPRITES(2), .MEM_AW(18), .MEM_DW(32)) dut (
    .clk_draw_i(clk), .rst_draw_i(rst), .line_i(line), .enable_i(enable),
    .sprite_index_o(sprite_index), .valid_i(valid),
    .tilemap_addr_i(tilemap_addr), .bitmap_addr_i(bitmap_addr),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .lb_we_o(lb_we), .lb_x_o(lb_x), .lb_flip_o(lb_flip), .lb_data_o(lb_data),
    .busy_o(busy), .overrun_o(overrun)
  );

  active_tilemap_addr_t tm_tbl [0:3];
  active_bitmap_addr_t  bm_tbl [0:3];
  int n_ent = 0;

  always @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tilemap_addr <= '0;
      bitmap_addr <= '0;
    end else begin
      valid <= ({23'b0, sprite_index} < n_ent);
      tilemap_addr <= tm_tbl[sprite_index[1:0]];
      bitmap_addr <= bm_tbl[sprite_index[1:0]];
    end
  end

  int   gnt_delay = 0, rd_lat = 2, wait_cnt = 0, pend_cnt = 0;
  bit   force_gnt = 1'b0;
  logic [17:0] pend_addr = '0;

  function automatic logic [31:0] word(input logic [17:0] a);
    return 32'hC000_0000 | {14'b0, a};
  endfunction

  assign mem_gnt = force_gnt | (mem_req && (wait_cnt >= gnt_delay));

  always @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 0; pend_cnt <= 0; mem_rvalid <= 1'b0; mem_rdata <= '0;
    end else begin
      wait_cnt <= (mem_req && !mem_gnt) ? wait_cnt + 1 : 0;
      mem_rvalid <= 1'b0;
      if (pend_cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata <= word(pend_addr);
      end
      if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
      if (mem_req && mem_gnt) begin
        pend_cnt <= rd_lat;
        pend_addr <= mem_addr;
      end
    end
  end

  logic [17:0] rd_log [0:63];
  logic [10:0] wx_log [0:63];
  logic        wf_log [0:63];
  logic [31:0] wd_log [0:63];
  int rd_n = 0, lb_n = 0, stall_n = 0, ovr_n = 0, rv_n = 0, hold_viol = 0;
  logic        hold_q = 1'b0;
  logic [17:0] hold_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt) begin
        if (rd_n < 64) rd_log[rd_n] <= mem_addr;
        rd_n <= rd_n + 1;
      end
      if (mem_req && !mem_gnt) stall_n <= stall_n + 1;
      if (lb_we) begin
        if (lb_n < 64) begin
          wx_log[lb_n] <= lb_x; wf_log[lb_n] <= lb_flip; wd_log[lb_n] <= lb_data;
        end
        lb_n <= lb_n + 1;
      end
      if (overrun) ovr_n <= ovr_n + 1;
      if (mem_rvalid) rv_n <= rv_n + 1;
      if (hold_q && (!mem_req || mem_addr != hold_addr)) hold_viol <= hold_viol + 1;
    end
    hold_q <= mem_req && !mem_gnt && !rst;
    hold_addr <= mem_addr;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ent(input int i, input logic [17:0] tm, input logic [4:0] tc,
                         input logic fl, input logic [10:0] lbx, input logic [17:0] bm);
    tm_tbl[i] = '{tilemap_addr: tm, tile_count: tc, x_flip: fl};
    bm_tbl[i] = '{lb_addr: lbx, tile_bitmap_addr: bm};
  endtask

  task automatic pulse_line(input logic en);
    line = 1'b1; enable = en;
    @(negedge clk);
    line = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    if (busy) chk({tag, "_timeout"}, busy, 1'b0);
  endtask

  task automatic chk_rd(input string tag, input int idx, input logic [17:0] exp);
    chk($sformatf("%s_rd%0d", tag, idx), rd_log[idx], exp);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [10:0] x,
                        input logic f, input logic [31:0] d);
    chk($sformatf("%s_x%0d", tag, idx), wx_log[idx], x);
    chk($sformatf("%s_flip%0d", tag, idx), wf_log[idx], f);
    chk($sformatf("%s_data%0d", tag, idx), wd_log[idx], d);
  endtask

  int rb, lbb, ob, sb, hb, vb;

  task automatic snap();
    rb = rd_n; lbb = lb_n; ob = ovr_n; sb = stall_n; hb = hold_viol; vb = rv_n;
  endtask

  initial begin
    rst = 1'b1; line = 1'b0; enable = 1'b0;
    for (int i = 0; i < 4; i++) set_ent(i, '0, '0, 1'b0, '0, '0);
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_ctrl", {busy, mem_req, lb_we, overrun, lb_flip}, 5'b0);
    chk("rst_idx", sprite_index, 9'd0);
    chk("rst_addr", mem_addr, 18'd0);
    chk("rst_lbx", lb_x, 11'd0);
    chk("rst_lbd", lb_data, 32'd0);

    // Empty list, with gnt held high while no request is pending.
    snap(); n_ent = 0; force_gnt = 1'b1;
    pulse_line(1'b1);
    chk("empty_busy", busy, 1'b1);
    step(2);
    chk("empty_done", busy, 1'b0);
    step(3);
    chk("empty_reads", rd_n - rb, 0);
    chk("empty_writes", lb_n - lbb, 0);
    force_gnt = 1'b0;

    snap(); n_ent = 1; set_ent(0, 18'h100, 5'd1, 1'b0, 11'd100, 18'h2000);
    pulse_line(1'b0);
    chk("dis_busy", busy, 1'b0);
    step(4);
    chk("dis_reads", rd_n - rb, 0);

    snap();
    pulse_line(1'b1); wait_idle("t2", 300);
    chk("t2_nrd", rd_n - rb, 4);
    chk_rd("t2", rb + 0, 18'h100); chk_rd("t2", rb + 1, 18'h2100);
    chk_rd("t2", rb + 2, 18'h101); chk_rd("t2", rb + 3, 18'h2101);
    chk("t2_nwr", lb_n - lbb, 2);
    chk_wr("t2", lbb + 0, 11'd100, 1'b0, 32'hC000_2100);
    chk_wr("t2", lbb + 1, 11'd116, 1'b0, 32'hC000_2101);
    chk("t2_idx", sprite_index, 9'd1);
    chk("t2_ovr", ovr_n - ob, 0);

    snap(); set_ent(0, 18'h100, 5'd1, 1'b1, 11'd100, 18'h2000); force_gnt = 1'b1;
    pulse_line(1'b1); wait_idle("t3", 300);
    chk("t3_nrd", rd_n - rb, 4);
    chk("t3_nwr", lb_n - lbb, 2);
    chk_wr("t3", lbb + 0, 11'd116, 1'b1, 32'hC000_2100);
    chk_wr("t3", lbb + 1, 11'd100, 1'b1, 32'hC000_2101);
    force_gnt = 1'b0;

    // Withheld grant, bitmap address wrapping at 2^18 and lb_x wrapping at 2^11.
    snap(); gnt_delay = 5; set_ent(0, 18'h3F0, 5'd1, 1'b0, 11'd2040, 18'h3FF80);
    pulse_line(1'b1); wait_idle("t4", 500);
    chk("t4_nrd", rd_n - rb, 4);
    chk_rd("t4", rb + 0, 18'h3F0); chk_rd("t4", rb + 1, 18'h170);
    chk_rd("t4", rb + 2, 18'h3F1); chk_rd("t4", rb + 3, 18'h171);
    chk("t4_stall", stall_n - sb, 20);
    chk("t4_hold", hold_viol - hb, 0);
    chk("t4_rvalid", rv_n - vb, 4);
    chk("t4_nwr", lb_n - lbb, 2);
    chk_wr("t4", lbb + 0, 11'd2040, 1'b0, 32'hC000_0170);
    chk_wr("t4", lbb + 1, 11'd8, 1'b0, 32'hC000_0171);
    gnt_delay = 0;

    snap(); n_ent = 3;
    set_ent(0, 18'h010, 5'd0, 1'b0, 11'd0, 18'h1000);
    set_ent(1, 18'h020, 5'd0, 1'b0, 11'd200, 18'h1000);
    set_ent(2, 18'h030, 5'd0, 1'b0, 11'd400, 18'h1000);
    pulse_line(1'b1); wait_idle("t5", 400);
    chk("t5_nrd", rd_n - rb, 4);
    chk_rd("t5", rb + 0, 18'h010); chk_rd("t5", rb + 1, 18'h1010);
    chk_rd("t5", rb + 2, 18'h020); chk_rd("t5", rb + 3, 18'h1020);
    chk("t5_nwr", lb_n - lbb, 2);
    chk_wr("t5", lbb + 0, 11'd0, 1'b0, 32'hC000_1010);
    chk_wr("t5", lbb + 1, 11'd200, 1'b0, 32'hC000_1020);
    chk("t5_idx", sprite_index, 9'd2);

    // Line arrives while the first bitmap read is in flight.
    snap(); n_ent = 1; set_ent(0, 18'h100, 5'd1, 1'b0, 11'd100, 18'h2000); rd_lat = 4;
    pulse_line(1'b1);
    for (int i = 0; i < 100 && !(mem_req && mem_gnt && mem_addr == 18'h2100); i++) @(negedge clk);
    chk("t6_bmp_gnt", mem_addr, 18'h2100);
    step(1);
    pulse_line(1'b1);
    chk("t6_ovr_hi", overrun, 1'b1);
    chk("t6_busy", busy, 1'b1);
    step(1);
    chk("t6_ovr_lo", overrun, 1'b0);
    wait_idle("t6", 400);
    chk("t6_nrd", rd_n - rb, 6);
    chk_rd("t6", rb + 2, 18'h100); chk_rd("t6", rb + 3, 18'h2100);
    chk_rd("t6", rb + 4, 18'h101); chk_rd("t6", rb + 5, 18'h2101);
    chk("t6_nwr", lb_n - lbb, 2);
    chk_wr("t6", lbb + 0, 11'd100, 1'b0, 32'hC000_2100);
    chk_wr("t6", lbb + 1, 11'd116, 1'b0, 32'hC000_2101);
    chk("t6_novr", ovr_n - ob, 1);
    rd_lat = 2;

    // Reset while a request is being held.
    gnt_delay = 5;
    pulse_line(1'b1);
    step(2);
    chk("t7_req_before", mem_req, 1'b1);
    rst = 1'b1;
    step(1);
    chk("t7_ctrl", {busy, mem_req, lb_we, overrun, lb_flip}, 5'b0);
    chk("t7_idx", sprite_index, 9'd0);
    chk("t7_addr", mem_addr, 18'd0);
    chk("t7_lbx", lb_x, 11'd0);
    chk("t7_lbd", lb_data, 32'd0);
    rst = 1'b0; gnt_delay = 0;
    step(1);
    snap();
    pulse_line(1'b1); wait_idle("t7", 300);
    chk("t7_nwr", lb_n - lbb, 2);
    chk_wr("t7", lbb + 0, 11'd100, 1'b0, 32'hC000_2100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
